cal_result_acc: RTL and testbench
=================================

# cal_result_acc

Windowed accumulator placed directly downstream of the nibble-sum calculator. Consumes its 5-bit result and valid strobe, gathers WIN valid samples per window, and produces the window sum, maximum and minimum. Results leave through a one-entry registered valid/ready output. The calculator cannot be stalled, so a window that completes while the output slot is still occupied is dropped and flagged.

## Interface
- WIN, 4: samples per window; legal range 2..255.
- DW, 5: input sample width; matches the calculator result.
- SW, 7: sum width; must satisfy SW >= DW + ceil(log2(WIN)).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of window and output state.
- in_data  in  DW  sample from the calculator.
- in_valid  in  1  sample qualifier; no backpressure exists.
- out_sum  out  SW  sum of the WIN samples in the window.
- out_max  out  DW  largest sample in the window.
- out_min  out  DW  smallest sample in the window.
- out_valid  out  1  result register holds an unaccepted result.
- out_ready  in  1  consumer accepts the result when out_valid=1.
- ovf  out  1  sticky flag: at least one window result was dropped.
- cnt  out  8  valid samples collected so far in the current window (0..WIN-1).

## Operation
- Internal window state: cnt, acc_sum (SW bits), acc_max, acc_min.
  - Idle values: cnt=0, acc_sum=0, acc_max=0, acc_min=all ones.
- Sample with in_valid=1 and clr=0, not the last of its window (cnt<WIN-1):
  - cnt+1; acc_sum+in_data (zero-extended); acc_max=max(acc_max,in_data); acc_min=min(acc_min,in_data).
- Last sample of a window (cnt==WIN-1 and in_valid=1):
  - Final values are computed combinationally, including that sample.
  - Window state returns to idle values the same edge, so the next window starts at once.
- Output slot FSM, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1; out_sum/out_max/out_min are held stable.
- EMPTY -> FULL: a window completes.
- FULL -> EMPTY: out_ready=1 and no window completes this cycle.
- FULL -> FULL with new data: out_ready=1 and a window completes the same cycle. The new result loads and the accept counts.
- FULL, out_ready=0, window completes: the new result is discarded, ovf is set, and the held result is unchanged. Window state still restarts.
- out_* data values persist after acceptance until the next load; the consumer qualifies them only with out_valid.
- clr=1:
  - Next edge: cnt=0, accumulators to idle values, out_valid=0, ovf=0.
  - An in_valid sample in the same cycle is discarded.
  - clr has priority over every other event.
- Arithmetic is unsigned. The SW constraint makes sum overflow impossible.
- ovf clears only on clr or rst.

## Timing
- Reset values (rst=0, asynchronous): out_sum=0, out_max=0, out_min=0, out_valid=0, ovf=0, cnt=0; internal acc_min=all ones.
- Latency: out_valid rises on the edge that samples the last in_valid of a window. Result visible 1 cycle after the last sample is presented.
- Throughput: one sample per cycle sustained. Back-to-back windows need out_ready held high every cycle out_valid=1.
- Handshake transfer occurs on an edge where out_valid=1 and out_ready=1. out_ready while out_valid=0 has no effect.
- Reset asserted mid-window or while FULL: partial window and pending result are lost. First sample after rst release starts a new window at cnt=0.
- Gaps in in_valid do not affect window contents. cnt holds during gaps.

## Test plan
- Basic window: out_ready=1; samples 3,5,7,9 on consecutive cycles -> 1 cycle after the fourth, out_valid=1, out_sum=24, out_max=9, out_min=3; cnt back to 0; ovf=0.
- Gappy input and extremes: samples 31,0,31,31 with 2 idle cycles between each -> out_sum=93, out_max=31, out_min=0; cnt shows 1,2,3 during the gaps.
- Backpressure drop:
  - Stimulus: out_ready=0; windows {1,1,1,1} then {2,2,2,2}; then out_ready=1.
  - Required: out_sum stays 4 throughout; ovf=1 after the second window; the result is accepted with out_sum=4; out_valid falls; ovf stays 1.
- Simultaneous accept and completion:
  - Stimulus: FULL with out_sum=4; out_ready=1 on the same cycle a window {6,6,6,6} completes.
  - Required: out_valid stays 1; out_sum=24 next cycle; ovf=0.
- clr mid-window: samples 8,8 then clr=1 together with in_valid for a sample 8, then samples 1,2,3,4 -> cnt=0 after clr; next result out_sum=10, out_max=4, out_min=1; ovf=0.
- Async reset while FULL and mid-window:
  - Stimulus: rst low for 2 cycles, asynchronous to clk.
  - Required: all outputs 0 immediately; samples 2,2,2,2 after release -> out_sum=8.

Source files
------------

// File: rtl/cal_result_acc.sv
// ---------------------------------------------------------------------------
// cal_result_acc
//
// Windowed accumulator that sits directly behind the nibble-sum calculator.
// It gathers WIN valid samples per window and reports the window sum,
// maximum and minimum through a one-entry registered valid/ready slot.
// The calculator cannot be stalled, so a window that completes while the
// slot still holds an unaccepted result is dropped, and the sticky ovf flag
// records that.
//
// Parameters
//   WIN  samples per window (2..255)
//   DW   input sample width
//   SW   sum width, SW >= DW + ceil(log2(WIN))
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-low
//   clr        in   synchronous clear of window and output state
//   in_data    in   DW-bit sample from the calculator
//   in_valid   in   sample qualifier (no backpressure towards the source)
//   out_sum    out  SW-bit window sum
//   out_max    out  largest sample in the window
//   out_min    out  smallest sample in the window
//   out_valid  out  slot holds a result the consumer has not yet taken
//   out_ready  in   consumer accepts the result when out_valid=1
//   ovf        out  sticky: at least one window result was dropped
//   cnt        out  samples collected so far in the current window
// ---------------------------------------------------------------------------
module cal_result_acc #(
    parameter int WIN = 4,
    parameter int DW  = 5,
    parameter int SW  = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic [SW-1:0] out_sum,
    output logic [DW-1:0] out_max,
    output logic [DW-1:0] out_min,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          ovf,
    output logic [7:0]    cnt
);

    localparam logic [7:0]    WIN_LAST = 8'(WIN - 1);
    localparam logic [DW-1:0] MIN_IDLE = {DW{1'b1}};

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_t;

    // Unsigned compare helpers for the running extremes.
    function automatic logic [DW-1:0] umax(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] umin(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Window state
    logic [7:0]    cnt_q,     cnt_d;
    logic [SW-1:0] acc_sum_q, acc_sum_d;
    logic [DW-1:0] acc_max_q, acc_max_d;
    logic [DW-1:0] acc_min_q, acc_min_d;

    // Output slot
    slot_t         state_q;
    logic [SW-1:0] out_sum_q;
    logic [DW-1:0] out_max_q;
    logic [DW-1:0] out_min_q;
    logic          out_valid_q;
    logic          ovf_q;

    // Window totals including the sample presented this cycle; these are
    // what gets loaded into the slot when the window closes.
    logic          take;
    logic          last;
    logic [SW-1:0] sum_fin;
    logic [DW-1:0] max_fin;
    logic [DW-1:0] min_fin;

    always_comb begin
        take    = in_valid & ~clr;
        last    = take && (cnt_q == WIN_LAST);
        sum_fin = acc_sum_q + SW'(in_data);
        max_fin = umax(acc_max_q, in_data);
        min_fin = umin(acc_min_q, in_data);

        cnt_d     = cnt_q;
        acc_sum_d = acc_sum_q;
        acc_max_d = acc_max_q;
        acc_min_d = acc_min_q;

        // Closing a window and clearing both return to idle values so the
        // next window can start on the very next sample.
        if (clr || last) begin
            cnt_d     = '0;
            acc_sum_d = '0;
            acc_max_d = '0;
            acc_min_d = MIN_IDLE;
        end else if (take) begin
            cnt_d     = cnt_q + 8'd1;
            acc_sum_d = sum_fin;
            acc_max_d = max_fin;
            acc_min_d = min_fin;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            acc_sum_q   <= '0;
            acc_max_q   <= '0;
            acc_min_q   <= MIN_IDLE;
            state_q     <= S_EMPTY;
            out_sum_q   <= '0;
            out_max_q   <= '0;
            out_min_q   <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_sum_q <= acc_sum_d;
            acc_max_q <= acc_max_d;
            acc_min_q <= acc_min_d;

            if (clr) begin
                // Result data is left in place; out_valid=0 already marks
                // it as meaningless to the consumer.
                state_q     <= S_EMPTY;
                out_valid_q <= 1'b0;
                ovf_q       <= 1'b0;
            end else begin
                case (state_q)
                    S_EMPTY: begin
                        if (last) begin
                            out_sum_q   <= sum_fin;
                            out_max_q   <= max_fin;
                            out_min_q   <= min_fin;
                            state_q     <= S_FULL;
                            out_valid_q <= 1'b1;
                        end
                    end
                    S_FULL: begin
                        if (last) begin
                            if (out_ready) begin
                                // Accept and reload on the same edge.
                                out_sum_q <= sum_fin;
                                out_max_q <= max_fin;
                                out_min_q <= min_fin;
                            end else begin
                                // Slot still occupied: drop the new window.
                                ovf_q <= 1'b1;
                            end
                        end else if (out_ready) begin
                            state_q     <= S_EMPTY;
                            out_valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q     <= S_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_sum   = out_sum_q;
    assign out_max   = out_max_q;
    assign out_min   = out_min_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_cal_result_acc.sv
// ---------------------------------------------------------------------------
// tb_cal_result_acc
//
// Directed bench for cal_result_acc (WIN=4, DW=5, SW=7). Inputs change 1 ns
// after a rising edge; outputs are checked at that same point, so each check
// sees the state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_cal_result_acc;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [4:0] in_data;
    logic       in_valid;
    logic [6:0] out_sum;
    logic [4:0] out_max;
    logic [4:0] out_min;
    logic       out_valid;
    logic       out_ready;
    logic       ovf;
    logic [7:0] cnt;

    int errors = 0;
    int checks = 0;

    cal_result_acc #(.WIN(4), .DW(5), .SW(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_sum   (out_sum),
        .out_max   (out_max),
        .out_min   (out_min),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] s);
        in_valid = 1'b1;
        in_data  = s;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        checks++; if (out_sum !== 7'd0)   begin errors++; $display("FAIL reset_sum: got %0d want 0", out_sum); end
        checks++; if (out_max !== 5'd0)   begin errors++; $display("FAIL reset_max: got %0d want 0", out_max); end
        checks++; if (out_min !== 5'd0)   begin errors++; $display("FAIL reset_min: got %0d want 0", out_min); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (cnt !== 8'd0)       begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(5'd3); send(5'd5); send(5'd7); send(5'd9);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (out_sum !== 7'd24)  begin errors++; $display("FAIL basic_sum: got %0d want 24", out_sum); end
        checks++; if (out_max !== 5'd9)   begin errors++; $display("FAIL basic_max: got %0d want 9", out_max); end
        checks++; if (out_min !== 5'd3)   begin errors++; $display("FAIL basic_min: got %0d want 3", out_min); end
        checks++; if (cnt !== 8'd0)       begin errors++; $display("FAIL basic_cnt: got %0d want 0", cnt); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got %b want 0", out_valid); end
        checks++; if (out_sum !== 7'd24)  begin errors++; $display("FAIL basic_persist: got %0d want 24", out_sum); end
    endtask

    task automatic test_gappy();
        out_ready = 1'b1;
        send(5'd31);
        step(); step();
        checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL gap_cnt1: got %0d want 1", cnt); end
        send(5'd0);
        step(); step();
        checks++; if (cnt !== 8'd2) begin errors++; $display("FAIL gap_cnt2: got %0d want 2", cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_early: got %b want 0", out_valid); end
        send(5'd31);
        step(); step();
        checks++; if (cnt !== 8'd3) begin errors++; $display("FAIL gap_cnt3: got %0d want 3", cnt); end
        send(5'd31);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b want 1", out_valid); end
        checks++; if (out_sum !== 7'd93)  begin errors++; $display("FAIL gap_sum: got %0d want 93", out_sum); end
        checks++; if (out_max !== 5'd31)  begin errors++; $display("FAIL gap_max: got %0d want 31", out_max); end
        checks++; if (out_min !== 5'd0)   begin errors++; $display("FAIL gap_min: got %0d want 0", out_min); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(5'd1); send(5'd1); send(5'd1); send(5'd1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid1: got %b want 1", out_valid); end
        checks++; if (out_sum !== 7'd4)   begin errors++; $display("FAIL bp_sum1: got %0d want 4", out_sum); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL bp_ovf_early: got %b want 0", ovf); end
        send(5'd2); send(5'd2); send(5'd2);
        checks++; if (out_sum !== 7'd4)   begin errors++; $display("FAIL bp_sum_hold: got %0d want 4", out_sum); end
        send(5'd2);
        checks++; if (ovf !== 1'b1)       begin errors++; $display("FAIL bp_ovf: got %b want 1", ovf); end
        checks++; if (out_sum !== 7'd4)   begin errors++; $display("FAIL bp_sum_kept: got %0d want 4", out_sum); end
        checks++; if (out_max !== 5'd1)   begin errors++; $display("FAIL bp_max_kept: got %0d want 1", out_max); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid2: got %b want 1", out_valid); end
        checks++; if (cnt !== 8'd0)       begin errors++; $display("FAIL bp_cnt: got %0d want 0", cnt); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_accept: got %b want 0", out_valid); end
        checks++; if (ovf !== 1'b1)       begin errors++; $display("FAIL bp_ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_back_to_back();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL b2b_clr_ovf: got %b want 0", ovf); end
        out_ready = 1'b0;
        send(5'd1); send(5'd1); send(5'd1); send(5'd1);
        checks++; if (out_sum !== 7'd4)   begin errors++; $display("FAIL b2b_sum1: got %0d want 4", out_sum); end
        send(5'd6); send(5'd6); send(5'd6);
        out_ready = 1'b1;
        send(5'd6);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
        checks++; if (out_sum !== 7'd24)  begin errors++; $display("FAIL b2b_sum2: got %0d want 24", out_sum); end
        checks++; if (out_min !== 5'd6)   begin errors++; $display("FAIL b2b_min: got %0d want 6", out_min); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept: got %b want 0", out_valid); end
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        send(5'd8); send(5'd8);
        checks++; if (cnt !== 8'd2) begin errors++; $display("FAIL clr_pre_cnt: got %0d want 2", cnt); end
        clr = 1'b1;
        send(5'd8);
        clr = 1'b0;
        checks++; if (cnt !== 8'd0)       begin errors++; $display("FAIL clr_cnt: got %0d want 0", cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", out_valid); end
        send(5'd1); send(5'd2); send(5'd3); send(5'd4);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_res_valid: got %b want 1", out_valid); end
        checks++; if (out_sum !== 7'd10)  begin errors++; $display("FAIL clr_sum: got %0d want 10", out_sum); end
        checks++; if (out_max !== 5'd4)   begin errors++; $display("FAIL clr_max: got %0d want 4", out_max); end
        checks++; if (out_min !== 5'd1)   begin errors++; $display("FAIL clr_min: got %0d want 1", out_min); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL clr_ovf: got %b want 0", ovf); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(5'd5); send(5'd5); send(5'd5); send(5'd5);
        send(5'd7); send(5'd7);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b want 1", out_valid); end
        checks++; if (cnt !== 8'd2)       begin errors++; $display("FAIL ar_pre_cnt: got %0d want 2", cnt); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        checks++; if (out_sum !== 7'd0)   begin errors++; $display("FAIL ar_sum: got %0d want 0", out_sum); end
        checks++; if (out_max !== 5'd0)   begin errors++; $display("FAIL ar_max: got %0d want 0", out_max); end
        checks++; if (out_min !== 5'd0)   begin errors++; $display("FAIL ar_min: got %0d want 0", out_min); end
        checks++; if (cnt !== 8'd0)       begin errors++; $display("FAIL ar_cnt: got %0d want 0", cnt); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL ar_ovf: got %b want 0", ovf); end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        out_ready = 1'b1;
        send(5'd2); send(5'd2); send(5'd2); send(5'd2);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_post_valid: got %b want 1", out_valid); end
        checks++; if (out_sum !== 7'd8)   begin errors++; $display("FAIL ar_post_sum: got %0d want 8", out_sum); end
        checks++; if (out_min !== 5'd2)   begin errors++; $display("FAIL ar_post_min: got %0d want 2", out_min); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gappy();
        test_backpressure();
        test_back_to_back();
        test_clr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
